// File: rtl/program_loader.sv
// Assembles UART bytes (low byte first) into instruction words and writes them
// sequentially into instruction memory until a HALT opcode or a full memory.
module program_loader #(
  parameter int                   NB_INSTRUCTION = 16,
  parameter int                   NB_ADDR        = 10,
  parameter int                   NB_BYTE        = 8,
  parameter int                   NB_OPCODE      = 5,
  parameter logic [NB_OPCODE-1:0] HALT_OPCODE    = 5'b00000
) (
  input  logic                      i_clock,
  input  logic                      i_reset_n,
  input  logic                      i_start,
  input  logic [NB_BYTE-1:0]        i_rx_data,
  input  logic                      i_rx_valid,
  output logic                      o_write_enable,
  output logic [NB_ADDR-1:0]        o_write_address,
  output logic [NB_INSTRUCTION-1:0] o_data,
  output logic                      o_busy,
  output logic                      o_done,
  output logic                      o_overflow,
  output logic [NB_ADDR:0]          o_word_count
);

  typedef enum logic [2:0] {
    IDLE,
    WAIT_LOW,
    WAIT_HIGH,
    WRITE,
    DONE
  } state_t;

  localparam logic [NB_ADDR-1:0] LAST_ADDR = '1;
  localparam logic [NB_ADDR-1:0] ADDR_ONE  = 1;
  localparam logic [NB_ADDR:0]   COUNT_ONE = 1;

  state_t state;

  function automatic logic is_halt(input logic [NB_INSTRUCTION-1:0] word);
    return word[NB_INSTRUCTION-1 -: NB_OPCODE] == HALT_OPCODE;
  endfunction

  always_ff @(posedge i_clock or negedge i_reset_n) begin
    if (!i_reset_n) begin
      state           <= IDLE;
      o_write_enable  <= 1'b0;
      o_write_address <= '0;
      o_data          <= '0;
      o_busy          <= 1'b0;
      o_done          <= 1'b0;
      o_overflow      <= 1'b0;
      o_word_count    <= '0;
    end else begin
      o_write_enable <= 1'b0;
      case (state)
        // A start here wins over a coincident byte, which is simply dropped.
        IDLE, DONE: begin
          if (i_start) begin
            state           <= WAIT_LOW;
            o_write_address <= '0;
            o_word_count    <= '0;
            o_done          <= 1'b0;
            o_overflow      <= 1'b0;
            o_busy          <= 1'b1;
          end
        end
        WAIT_LOW: begin
          if (i_rx_valid) begin
            o_data[NB_BYTE-1:0] <= i_rx_data;
            state               <= WAIT_HIGH;
          end
        end
        WAIT_HIGH: begin
          if (i_rx_valid) begin
            o_data[NB_INSTRUCTION-1:NB_BYTE] <= i_rx_data;
            o_write_enable                   <= 1'b1;
            state                            <= WRITE;
          end
        end
        // Single-cycle write; the address never wraps past the last location.
        WRITE: begin
          o_word_count <= o_word_count + COUNT_ONE;
          if (is_halt(o_data)) begin
            state      <= DONE;
            o_busy     <= 1'b0;
            o_done     <= 1'b1;
            o_overflow <= 1'b0;
          end else if (o_write_address == LAST_ADDR) begin
            state      <= DONE;
            o_busy     <= 1'b0;
            o_done     <= 1'b1;
            o_overflow <= 1'b1;
          end else begin
            o_write_address <= o_write_address + ADDR_ONE;
            state           <= WAIT_LOW;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
